// File: rtl/sound_pkg.sv
// sound_pkg: shared constants and helpers for sound_mixer_tapein and tape_slicer.
package sound_pkg;

  // Slicer envelope state after reset: a one-LSB window around mid-scale.
  localparam logic [7:0] LO_INIT  = 8'd127;
  localparam logic [7:0] HI_INIT  = 8'd128;
  localparam logic [7:0] AVG_INIT = 8'd127;
  localparam logic [7:0] MID_INIT = 8'd127;

  // Top byte of a two's-complement sample, re-biased to offset binary.
  function automatic logic [7:0] to_offset_bin(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

  // Number of set bits in a 16-bit vector (callers zero-extend narrower inputs).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tape_slicer.sv
// tape_slicer: adaptive-threshold 1-bit slicer for ADC tape input.
// Tracks a min/max envelope with slow decay toward a running average, derives the
// midpoint one edge later and compares the sample against it one edge after that.
// Hysteresis around the midpoint is enabled by defining SOUND_TAPEIN_HYST_EN.
module tape_slicer
  import sound_pkg::*;
#(
  parameter int DECAY_DIV = 65536,
  parameter int HYST      = 2
) (
  input  logic        i_clk18,
  input  logic        i_reset,
  input  logic [15:0] i_in_sample,
  input  logic        i_in_valid,
  output logic        o_tapein,
  output logic [7:0]  o_tape_mid
);

`ifdef SOUND_TAPEIN_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam int              DC_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECAY_DIV - 1);
  // With hysteresis off the window collapses to zero width.
  localparam logic [9:0]      HYST_V  = 10'(HYST_ON ? HYST : 0);

  logic [7:0]      w_u;
  logic            w_wrap;
  logic [8:0]      w_avg_sum;
  logic [9:0]      w_hi_sum;
  logic [7:0]      w_th_hi;
  logic [7:0]      w_th_lo;
  logic            w_clear;

  logic [7:0]      r_u;
  logic [7:0]      r_u_d;
  logic [7:0]      r_lo;
  logic [7:0]      r_hi;
  logic [7:0]      r_avg;
  logic [7:0]      r_mid;
  logic [DC_W-1:0] r_dcnt;
  logic            r_tapein;

  assign w_u       = to_offset_bin(i_in_sample);
  assign w_wrap    = (r_dcnt == DC_LAST);
  assign w_avg_sum = {1'b0, r_avg} + {1'b0, w_u};

  // Saturated thresholds around the midpoint.
  assign w_hi_sum  = {2'b00, r_mid} + HYST_V;
  assign w_th_hi   = (w_hi_sum > 10'd255) ? 8'hFF : w_hi_sum[7:0];
  assign w_th_lo   = ({2'b00, r_mid} < HYST_V) ? 8'h00 : (r_mid - HYST_V[7:0]);
  // Without hysteresis anything not above the midpoint clears the output.
  assign w_clear   = HYST_ON ? (r_u_d < w_th_lo) : 1'b1;

  // Envelope capture, running average and decay toward the average.
  always_ff @(posedge i_clk18 or posedge i_reset) begin
    if (i_reset) begin
      r_u    <= '0;
      r_lo   <= LO_INIT;
      r_hi   <= HI_INIT;
      r_avg  <= AVG_INIT;
      r_dcnt <= '0;
    end else if (i_in_valid) begin
      r_u    <= w_u;
      r_avg  <= w_avg_sum[8:1];
      r_dcnt <= w_wrap ? '0 : r_dcnt + 1'b1;
      if (w_u < r_lo)                    r_lo <= w_u;
      else if (w_wrap && (r_lo < r_avg)) r_lo <= r_lo + 8'd1;
      if (w_u > r_hi)                    r_hi <= w_u;
      else if (w_wrap && (r_hi > r_avg)) r_hi <= r_hi - 8'd1;
    end
  end

  // Midpoint one edge behind the envelope, decision one edge behind the midpoint;
  // r_u_d keeps the sample aligned with the midpoint it was captured against.
  always_ff @(posedge i_clk18 or posedge i_reset) begin
    if (i_reset) begin
      r_mid    <= MID_INIT;
      r_u_d    <= '0;
      r_tapein <= 1'b0;
    end else begin
      r_mid <= r_lo + ((r_hi - r_lo) >> 1);
      r_u_d <= r_u;
      if (r_u_d > w_th_hi) r_tapein <= 1'b1;
      else if (w_clear)    r_tapein <= 1'b0;
    end
  end

  assign o_tapein   = r_tapein;
  assign o_tape_mid = r_mid;

endmodule

// File: rtl/sound_mixer_tapein.sv
// sound_mixer_tapein: pulse-channel mixer with boxcar decimation to a PCM
// valid/ready stream, plus the tape-in slicer (tape_slicer) on the ADC path.
// Build option: define SOUND_TAPEIN_HYST_EN for slicer hysteresis of HYST LSBs.
module sound_mixer_tapein
  import sound_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int AVG_DEPTH = 4,
  parameter int DECIM     = 512,
  parameter int OUT_W     = 16,
  parameter int DECAY_DIV = 65536,
  parameter int HYST      = 2
) (
  input  logic                i_clk18,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_pulses,
  input  logic [CHANNELS-1:0] i_ch_enable,
  output logic [OUT_W-1:0]    o_out_sample,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_overrun,
  input  logic [15:0]         i_in_sample,
  input  logic                i_in_valid,
  output logic                o_tapein,
  output logic [7:0]          o_tape_mid
);

  localparam int               ACC_W    = $clog2(CHANNELS * AVG_DEPTH + 1);
  localparam int               SH       = OUT_W - 1 - ACC_W;
  localparam int               DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  logic [DEC_W-1:0] r_dec_cnt;
  logic             w_ce;
  logic [15:0]      w_active;
  logic [ACC_W-1:0] w_mix;
  logic [OUT_W-1:0] w_out_val;

  logic [ACC_W-1:0] r_mix;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_dly [AVG_DEPTH];
  logic             r_ce_d1;
  logic             r_ce_d2;
  logic [OUT_W-1:0] r_out_sample;
  logic             r_out_valid;
  logic             r_overrun;

  assign w_ce      = (r_dec_cnt == DEC_LAST);
  assign w_active  = 16'(i_pulses & i_ch_enable);
  assign w_mix     = ACC_W'(popcount16(w_active));
  // The sum is always non-negative, so the sign bit of the PCM word stays clear.
  assign w_out_val = OUT_W'(r_acc) << SH;

  // Sample-rate strobe generator.
  always_ff @(posedge i_clk18 or posedge i_reset) begin
    if (i_reset)   r_dec_cnt <= '0;
    else if (w_ce) r_dec_cnt <= '0;
    else           r_dec_cnt <= r_dec_cnt + 1'b1;
  end

  // Mix on the strobe, then slide the boxcar window one edge later.
  always_ff @(posedge i_clk18 or posedge i_reset) begin
    if (i_reset) begin
      r_mix   <= '0;
      r_acc   <= '0;
      r_ce_d1 <= 1'b0;
      r_ce_d2 <= 1'b0;
      for (int i = 0; i < AVG_DEPTH; i++) r_dly[i] <= '0;
    end else begin
      r_ce_d1 <= w_ce;
      r_ce_d2 <= r_ce_d1;
      if (w_ce) r_mix <= w_mix;
      if (r_ce_d1) begin
        r_acc <= r_acc + r_mix - r_dly[AVG_DEPTH-1];
        for (int i = AVG_DEPTH - 1; i > 0; i--) r_dly[i] <= r_dly[i-1];
        r_dly[0] <= r_mix;
      end
    end
  end

  // Output holding register: a new sample always wins over a pending transfer.
  always_ff @(posedge i_clk18 or posedge i_reset) begin
    if (i_reset) begin
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_ce_d2) begin
      r_out_sample <= w_out_val;
      r_out_valid  <= 1'b1;
      if (r_out_valid && !i_out_ready) r_overrun <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_sample = r_out_sample;
  assign o_out_valid  = r_out_valid;
  assign o_overrun    = r_overrun;

  tape_slicer #(
    .DECAY_DIV (DECAY_DIV),
    .HYST      (HYST)
  ) u_tape_slicer (
    .i_clk18     (i_clk18),
    .i_reset     (i_reset),
    .i_in_sample (i_in_sample),
    .i_in_valid  (i_in_valid),
    .o_tapein    (o_tapein),
    .o_tape_mid  (o_tape_mid)
  );

endmodule

// File: tb/tb_sound_mixer_tapein.sv
// tb_sound_mixer_tapein: random and directed stimulus against a behavioural model
// of the mixer stream and tape slicer. Follows SOUND_TAPEIN_HYST_EN like the RTL.
module tb_sound_mixer_tapein;

  localparam int CHANNELS  = 4;
  localparam int AVG_DEPTH = 4;
  localparam int DECIM     = 32;
  localparam int OUT_W     = 16;
  localparam int DECAY_DIV = 16;
  localparam int HYST      = 2;
  localparam int ACC_W     = $clog2(CHANNELS * AVG_DEPTH + 1);
  localparam int SH        = OUT_W - 1 - ACC_W;
`ifdef SOUND_TAPEIN_HYST_EN
  localparam bit HYS_ON = 1'b1;
`else
  localparam bit HYS_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CHANNELS-1:0] pulses = '0;
  logic [CHANNELS-1:0] en = '0;
  logic                ready = 1'b0;
  logic [15:0]         in_sample = '0;
  logic                in_valid = 1'b0;
  logic [OUT_W-1:0]    out_sample;
  logic                out_valid;
  logic                overrun;
  logic                tapein;
  logic [7:0]          tape_mid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sound_mixer_tapein #(
    .CHANNELS (CHANNELS), .AVG_DEPTH (AVG_DEPTH), .DECIM (DECIM),
    .OUT_W (OUT_W), .DECAY_DIV (DECAY_DIV), .HYST (HYST)
  ) dut (
    .i_clk18      (clk),
    .i_reset      (rst),
    .i_pulses     (pulses),
    .i_ch_enable  (en),
    .o_out_sample (out_sample),
    .o_out_valid  (out_valid),
    .i_out_ready  (ready),
    .o_overrun    (overrun),
    .i_in_sample  (in_sample),
    .i_in_valid   (in_valid),
    .o_tapein     (tapein),
    .o_tape_mid   (tape_mid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int at; int val; } load_t;
  int    m_edge, m_cnt;
  int    hist[$];
  load_t loads[$];
  int    m_sample, m_valid, m_ovr;
  int    m_lo, m_hi, m_avg, m_dcnt, m_u, m_u_old, m_mid, m_tap;

  task automatic model_reset();
    m_cnt = 0; hist.delete(); loads.delete();
    m_sample = 0; m_valid = 0; m_ovr = 0;
    m_lo = 127; m_hi = 128; m_avg = 127; m_dcnt = 0;
    m_u = 0; m_u_old = 0; m_mid = 127; m_tap = 0;
  endtask

  function automatic int tap_rule(input int u, input int mid, input int prev);
    int th_hi, th_lo;
    if (!HYS_ON) return (u > mid) ? 1 : 0;
    th_hi = (mid + HYST > 255) ? 255 : mid + HYST;
    th_lo = (mid - HYST < 0) ? 0 : mid - HYST;
    if (u > th_hi) return 1;
    if (u < th_lo) return 0;
    return prev;
  endfunction

  function automatic logic [15:0] u2s(input int v);
    return 16'(v * 256 - 32768);
  endfunction

  task automatic compare_all();
    check_val("out_valid", out_valid, m_valid);
    check_val("out_sample", out_sample, m_sample);
    check_val("overrun", overrun, m_ovr);
    check_val("tapein", tapein, m_tap);
    check_val("tape_mid", tape_mid, m_mid);
  endtask

  // Advance the model over the next clock edge with the current inputs, then compare.
  task automatic step();
    int mix, sum, u, nm, nt, nlo, nhi;
    bit decay;
    load_t ld;
    if (rst) model_reset();
    else begin
      m_edge++;
      if (m_cnt == DECIM - 1) begin
        mix = $countones(pulses & en);
        hist.push_back(mix);
        if (hist.size() > AVG_DEPTH) void'(hist.pop_front());
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        ld.at = m_edge + 2; ld.val = sum << SH;
        loads.push_back(ld);
        m_cnt = 0;
      end else m_cnt++;
      if (loads.size() > 0 && loads[0].at == m_edge) begin
        if (m_valid != 0 && !ready) m_ovr = 1;
        m_sample = loads[0].val; m_valid = 1;
        void'(loads.pop_front());
      end else if (m_valid != 0 && ready) m_valid = 0;
      nt = tap_rule(m_u_old, m_mid, m_tap);
      nm = m_lo + (m_hi - m_lo) / 2;
      m_u_old = m_u;
      if (in_valid) begin
        u = (int'($signed(in_sample)) + 32768) / 256;
        decay = (m_dcnt == DECAY_DIV - 1);
        m_dcnt = (m_dcnt + 1) % DECAY_DIV;
        nlo = (u < m_lo) ? u : (decay && m_lo < m_avg) ? m_lo + 1 : m_lo;
        nhi = (u > m_hi) ? u : (decay && m_hi > m_avg) ? m_hi - 1 : m_hi;
        m_avg = (m_avg + u) / 2;
        m_lo = nlo; m_hi = nhi; m_u = u;
      end
      m_mid = nm; m_tap = nt;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rand_step();
    pulses    = CHANNELS'($urandom);
    en        = CHANNELS'($urandom);
    ready     = ($urandom_range(0, 3) != 0);
    in_sample = 16'($urandom);
    in_valid  = 1'($urandom);
    step();
  endtask

  task automatic slice_one(input int v);
    in_sample = u2s(v); in_valid = 1'b1; step();
    in_valid = 1'b0; step(); step();
  endtask

  initial begin
    m_edge = 0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;

    pulses = '1; en = '1; ready = 1'b1;
    repeat (6 * DECIM) step();
    check_val("steady_full", out_sample, 32'h4000);
    en = 4'b0001;
    repeat (6 * DECIM) step();
    check_val("one_channel", out_sample, 32'h1000);
    en = '0;
    repeat (5 * DECIM) step();
    check_val("muted", out_sample, 32'h0000);

    en = '1; ready = 1'b0;
    repeat (3 * DECIM) step();
    check_val("overrun_set", overrun, 1);
    check_val("valid_held", out_valid, 1);
    ready = 1'b1;
    repeat (DECIM) step();
    check_val("overrun_sticky", overrun, 1);

    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_sample = (i % 4 < 2) ? 16'h4000 : 16'hC000;
      step();
    end
    in_sample = 16'h4000; step();
    in_sample = 16'hC000; step();
    in_valid = 1'b0;
    repeat (3) step();
    check_val("square_mid", tape_mid, 32'h80);

    in_valid = 1'b1; in_sample = 16'h0000;
    repeat (3 * DECAY_DIV) step();
    in_valid = 1'b0;
    repeat (3) step();

    slice_one(8'hC0);
    slice_one(8'h40);
    slice_one(8'h81);
    check_val("thr_81", tapein, HYS_ON ? 0 : 1);
    slice_one(8'h83);
    check_val("thr_83", tapein, 1);
    slice_one(8'h7F);
    check_val("thr_7f", tapein, HYS_ON ? 1 : 0);
    slice_one(8'h7D);
    check_val("thr_7d", tapein, 0);

    repeat (20 * DECIM) rand_step();

    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    repeat (3) rand_step();
    rst = 1'b0;
    repeat (6 * DECIM) rand_step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_mixer_tapein.md
# sound_mixer_tapein

Parametrised successor to the Vector-06C sound path: mixes CHANNELS one-bit pulse sources (8253 timer outputs, beeper, tape-out) into a boxcar-filtered PCM sample offered to the codec serializer over a valid/ready handshake. In the reverse direction, it slices ADC samples into a 1-bit tape-in signal with an adaptive envelope midpoint. Sits between the chipset pulse outputs / tape logic and the codec I2S serializer, all in the clk18 domain.

## Interface
- CHANNELS, 4: number of pulse inputs (1..16)
- AVG_DEPTH, 4: boxcar length in output samples, power of two (1..16)
- DECIM, 512: clk18 cycles per output sample
- OUT_W, 16: output sample width; must satisfy OUT_W-1 >= ACC_W
- DECAY_DIV, 65536: input samples between envelope decay steps, power of two
- HYST, 2: slicer hysteresis in LSBs of the 8-bit level
- clk18  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pulses  in  CHANNELS  raw pulse levels, sampled only on the sample strobe
- ch_enable  in  CHANNELS  per-channel enable; 0 mutes the channel
- out_sample  out  OUT_W  two's-complement PCM to serializer
- out_valid  out  1  out_sample valid
- out_ready  in  1  serializer accepts out_sample
- overrun  out  1  sticky: a sample was replaced before acceptance
- in_sample  in  16  two's-complement ADC sample
- in_valid  in  1  one-cycle strobe, in_sample valid
- tapein  out  1  sliced tape input level
- tape_mid  out  8  current slicer threshold (offset binary)

## Operation
- ACC_W = $clog2(CHANNELS*AVG_DEPTH+1).
- Decimator counts 0..DECIM-1 and wraps; strobe ce is high when count == DECIM-1.
- Mix pipeline:
  - edge with ce: mix_r <= popcount(pulses & ch_enable).
  - next edge: shift AVG_DEPTH-deep delay line; acc <= acc + mix_r - oldest. acc never exceeds CHANNELS*AVG_DEPTH.
  - next edge: out_sample <= acc << (OUT_W-1-ACC_W), zero-filled, always non-negative; out_valid <= 1.
- Handshake:
  - Transfer occurs on any edge with out_valid && out_ready; out_valid then drops unless a new sample loads on the same edge (load wins).
  - A load while out_valid && !out_ready replaces out_sample, keeps out_valid high, and sets overrun; overrun clears only on reset.
  - out_sample is otherwise stable while out_valid is high.
- Slicer, on the in_valid edge:
  - u <= {~in_sample[15], in_sample[14:8]} (offset binary).
  - If u < lo then lo <= u. If u > hi then hi <= u.
  - avg <= (avg + u) >> 1 (9-bit intermediate).
  - Decay counter increments; on wrap to 0: lo <= lo+1 if lo < avg, hi <= hi-1 if hi > avg. Capture overrides decay for the same register.
- Next edge: mid <= lo + ((hi - lo) >> 1), computed in 8 bits; hi >= lo holds by construction.
- Edge after that: tapein <= (u > mid).
- Reset values: out_sample 0, out_valid 0, overrun 0, acc 0, delay line 0, mix_r 0, decimator 0, lo 127, hi 128, avg 127, mid 127, tape_mid 127, tapein 0, decay counter 0.

## Timing
- Output sample: out_valid rises at the 3rd edge counting the ce edge as the 1st. Period DECIM cycles.
- Filter fill: a step input reaches full value after AVG_DEPTH samples.
- Tapein: updated at the 3rd edge counting the in_valid edge as the 1st. Back-to-back in_valid every cycle is legal; the pipeline is fully overlapped.
- Reset asserted mid-operation: all state returns to reset values asynchronously. First ce occurs DECIM cycles after release.

## Configuration
- SOUND_TAPEIN_HYST_EN defined:
  - tapein sets when u > sat(mid+HYST) and clears when u < sat(mid-HYST), otherwise holds.
  - sat clamps to 0..255.
- SOUND_TAPEIN_HYST_EN undefined:
  - plain comparison tapein = (u > mid).
  - HYST is ignored.

## Structure
- Package sound_pkg holds:
  - reset constants LO_INIT = 127, HI_INIT = 128, AVG_INIT = 127.
  - the offset-binary conversion function.
  - a popcount function.
- Sub-module tape_slicer holds the envelope tracker, decay counter, midpoint and comparator. The top level holds the decimator, mixer, boxcar and handshake.

## Test plan
- All 4 channels enabled, pulses = 4'hF constant, out_ready = 1: samples go 0x1000, 0x2000, 0x3000, then 0x4000 steady.
- pulses = 4'hF, ch_enable = 4'b0001: steady out_sample = 0x1000. ch_enable = 0: decays to 0x0000 within 4 samples.
- out_ready held 0 across two strobes: out_valid stays 1, out_sample updates, overrun = 1. Raising out_ready then drops out_valid next edge; overrun stays 1.
- ADC square wave ±0x4000 (u = 0xC0 / 0x40) for 100 samples:
  - lo = 0x40, hi = 0xC0, tape_mid = 0x80.
  - tapein follows the wave with a 2-cycle lag.
- Input held at u = 0x80 for 3*DECAY_DIV samples after the above: lo increments and hi decrements once per DECAY_DIV while away from avg.
- With SOUND_TAPEIN_HYST_EN and mid = 0x80:
  - u = 0x81 does not set tapein; u = 0x83 sets it.
  - u = 0x7F holds it; u = 0x7D clears it.
  - Reset pulse mid-stream restores tapein = 0, tape_mid = 127.
